// File: rtl/aqed_pkg.sv
// Shared A-QED harness package: default data width / FIFO depth and the
// word type used by the FIFO responder and the monitor harness.
package aqed_pkg;

    localparam int unsigned AQED_DATA_W = 16;
    localparam int unsigned AQED_DEPTH  = 128;

    typedef logic [AQED_DATA_W-1:0] aqed_word_t;

endpackage : aqed_pkg

// File: rtl/aqed_fifo_mem.sv
// Storage for the A-QED FIFO responder: DEPTH x DATA_W register array with one
// write port and one registered read port. Enables arrive already qualified by
// the caller (clk_en, flush, full/empty), so this block only stores and reads.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset (clears only the read register)
//   we     - write enable; waddr/wdata - write address / data
//   re     - read enable;  raddr       - read address
//   rdata  - registered read data, holds when re is low
module aqed_fifo_mem #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // A read and a write to the same slot (only possible when full) return the
    // old contents, which is the word the read is owed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule : aqed_fifo_mem

// File: rtl/aqed_fifo_responder.sv
// Golden FIFO model for the memory-core side of the A-QED harness. Accepts the
// monitor's write stream, returns read data one cycle after each accepted read
// with a valid pulse, and can flip bit 0 of a read word on demand.
//
// Ports:
//   clk, reset      - clock (rising edge), asynchronous active-low reset
//   clk_en          - global enable; low holds every register
//   flush           - synchronous occupancy clear (qualified by clk_en)
//   wen_in, data_in - write request / data
//   ren_in          - read request
//   inject_err      - flip bit 0 of the word read this cycle
//   data_out        - registered read data
//   valid_out       - one-cycle pulse when data_out carries a new word
//   full, empty     - occupancy flags
//   count           - occupancy, 0..DEPTH
//   overflow        - sticky: write dropped while full
//   underflow       - sticky: read requested while empty
module aqed_fifo_responder
    import aqed_pkg::*;
#(
    parameter int unsigned DATA_W = AQED_DATA_W,
    parameter int unsigned DEPTH  = AQED_DEPTH,
    parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              wen_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ren_in,
    input  logic              inject_err,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W:0]   FullCount = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);
    localparam logic [PTR_W:0]   CntOne    = (PTR_W + 1)'(1);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              inj_q, inj_d;
    logic              rd_acc, wr_acc;
    logic [DATA_W-1:0] mem_rdata;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);

    // A read frees the slot for a same-cycle write when full; no bypass when empty.
    assign rd_acc = clk_en & ren_in & ~empty & ~flush;
    assign wr_acc = clk_en & wen_in & ~flush & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inj_d    = inj_q;
        if (clk_en) begin
            if (flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
                valid_d  = 1'b0;
            end else begin
                valid_d = rd_acc;
                if (wr_acc) begin
                    wr_ptr_d = wr_ptr_q + PtrOne;
                end
                if (rd_acc) begin
                    rd_ptr_d = rd_ptr_q + PtrOne;
                    inj_d    = inject_err;
                end
                unique case ({wr_acc, rd_acc})
                    2'b10:   count_d = count_q + CntOne;
                    2'b01:   count_d = count_q - CntOne;
                    default: count_d = count_q;
                endcase
                if (wen_in && full && !rd_acc) begin
                    ovf_d = 1'b1;
                end
                if (ren_in && empty) begin
                    unf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inj_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inj_q    <= inj_d;
        end
    end

    aqed_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    // Injection flag is captured with the read so data_out stays stable while held.
    assign data_out  = mem_rdata ^ DATA_W'(inj_q);
    assign valid_out = valid_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule : aqed_fifo_responder

// File: tb/tb_aqed_fifo_responder.sv
// Directed bench for aqed_fifo_responder: a vector table for the basic
// order / empty cases, then hand-written sequences for full, wrap with clk_en
// gating, flush, asynchronous reset and error injection.
module tb_aqed_fifo_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        flush;
    logic        wen_in;
    logic [15:0] data_in;
    logic        ren_in;
    logic        inject_err;
    logic [15:0] data_out;
    logic        valid_out;
    logic        full;
    logic        empty;
    logic [7:0]  count;
    logic        overflow;
    logic        underflow;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    aqed_fifo_responder dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .flush      (flush),
        .wen_in     (wen_in),
        .data_in    (data_in),
        .ren_in     (ren_in),
        .inject_err (inject_err),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    typedef struct {
        logic        en;
        logic        fl;
        logic        wen;
        logic [15:0] din;
        logic        ren;
        logic        inj;
        logic        ev;
        logic [15:0] edat;
        logic [7:0]  ecnt;
        logic        eemp;
        logic        eunf;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock, then sample 1 time unit after the edge.
    task automatic step(input logic en, input logic fl, input logic wen, input logic [15:0] din,
                        input logic ren, input logic inj);
        clk_en     = en;
        flush      = fl;
        wen_in     = wen;
        data_in    = din;
        ren_in     = ren;
        inject_err = inj;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clk_en = 1'b0; flush = 1'b0; wen_in = 1'b0; data_in = '0; ren_in = 1'b0;
        inject_err = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] q [$];
        logic [15:0] last_d;
        logic        last_v;
        logic [15:0] orig, dup;

        // en fl wen din ren inj | ev edat cnt emp unf
        vecs[0]  = '{1, 0, 1, 16'h0011, 0, 0, 0, 16'h0000, 8'd1, 0, 0};
        vecs[1]  = '{1, 0, 1, 16'h0022, 0, 0, 0, 16'h0000, 8'd2, 0, 0};
        vecs[2]  = '{1, 0, 1, 16'h0033, 0, 0, 0, 16'h0000, 8'd3, 0, 0};
        vecs[3]  = '{1, 0, 0, 16'h0000, 1, 0, 1, 16'h0011, 8'd2, 0, 0};
        vecs[4]  = '{1, 0, 0, 16'h0000, 1, 0, 1, 16'h0022, 8'd1, 0, 0};
        vecs[5]  = '{1, 0, 0, 16'h0000, 1, 0, 1, 16'h0033, 8'd0, 1, 0};
        vecs[6]  = '{1, 0, 0, 16'h0000, 0, 0, 0, 16'h0033, 8'd0, 1, 0};
        vecs[7]  = '{1, 0, 0, 16'h0000, 1, 0, 0, 16'h0033, 8'd0, 1, 1};
        vecs[8]  = '{1, 0, 1, 16'h00AA, 1, 0, 0, 16'h0033, 8'd1, 0, 1};
        vecs[9]  = '{1, 0, 0, 16'h0000, 1, 0, 1, 16'h00AA, 8'd0, 1, 1};
        vecs[10] = '{0, 0, 1, 16'h5555, 1, 0, 1, 16'h00AA, 8'd0, 1, 1};
        vecs[11] = '{1, 0, 0, 16'h0000, 0, 0, 0, 16'h00AA, 8'd0, 1, 1};

        do_reset();
        check("reset valid_out", valid_out, 0);
        check("reset data_out", data_out, 0);
        check("reset count", count, 0);
        check("reset empty", empty, 1);
        check("reset full", full, 0);
        check("reset overflow", overflow, 0);
        check("reset underflow", underflow, 0);

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].en, vecs[i].fl, vecs[i].wen, vecs[i].din, vecs[i].ren, vecs[i].inj);
            check($sformatf("vec%0d valid_out", i), valid_out, vecs[i].ev);
            check($sformatf("vec%0d data_out", i), data_out, vecs[i].edat);
            check($sformatf("vec%0d count", i), count, vecs[i].ecnt);
            check($sformatf("vec%0d empty", i), empty, vecs[i].eemp);
            check($sformatf("vec%0d underflow", i), underflow, vecs[i].eunf);
        end

        // Full / overflow / read+write while full.
        do_reset();
        for (int i = 0; i < 128; i++) step(1, 0, 1, 16'(i), 0, 0);
        check("fill full", full, 1);
        check("fill count", count, 128);
        check("fill overflow clear", overflow, 0);
        step(1, 0, 1, 16'hBEEF, 0, 0);
        check("drop overflow", overflow, 1);
        check("drop count", count, 128);
        step(1, 0, 1, 16'h7777, 1, 0);
        check("rw full valid", valid_out, 1);
        check("rw full data", data_out, 16'h0000);
        check("rw full count", count, 128);
        check("rw full full", full, 1);
        for (int i = 1; i <= 128; i++) begin
            step(1, 0, 0, 16'h0, 1, 0);
            check($sformatf("drain%0d data", i), data_out, (i == 128) ? 16'h7777 : 16'(i));
        end
        check("drain empty", empty, 1);
        check("drain underflow", underflow, 0);

        // Wrap with clk_en toggling every other cycle.
        do_reset();
        q.delete();
        last_d = 16'h0;
        for (int i = 0; i < 200; i++) begin
            logic [15:0] din;
            din = 16'(i * 3 + 5);
            last_v = (q.size() > 0);
            if (last_v) last_d = q.pop_front();
            q.push_back(din);
            step(1, 0, 1, din, 1, 0);
            check($sformatf("wrap%0d valid", i), valid_out, last_v);
            check($sformatf("wrap%0d data", i), data_out, last_d);
            step(0, 0, 1, 16'hDEAD, 1, 1);
            check($sformatf("gate%0d valid held", i), valid_out, last_v);
            check($sformatf("gate%0d data held", i), data_out, last_d);
        end
        check("wrap count", count, 1);

        // Flush with read requested.
        do_reset();
        step(1, 0, 0, 16'h0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 16'h0100 + 16'(i), 0, 0);
        step(1, 0, 0, 16'h0, 1, 0);
        check("pre-flush data", data_out, 16'h0100);
        step(1, 1, 1, 16'hFFFF, 1, 0);
        check("flush count", count, 0);
        check("flush valid", valid_out, 0);
        check("flush data held", data_out, 16'h0100);
        check("flush empty", empty, 1);
        check("flush underflow held", underflow, 1);
        check("flush overflow held", overflow, 0);
        step(1, 0, 1, 16'h0ABC, 0, 0);
        step(1, 0, 0, 16'h0, 1, 0);
        check("post-flush data", data_out, 16'h0ABC);
        check("post-flush valid", valid_out, 1);

        // Asynchronous reset during a read pulse.
        do_reset();
        step(1, 0, 1, 16'h0042, 0, 0);
        step(1, 0, 1, 16'h0043, 0, 0);
        step(1, 0, 0, 16'h0, 1, 0);
        check("pre-areset valid", valid_out, 1);
        #1 reset = 1'b0;
        #1;
        check("areset valid", valid_out, 0);
        check("areset count", count, 0);
        check("areset data", data_out, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        step(1, 0, 0, 16'h0, 1, 0);
        check("areset no stale read", valid_out, 0);

        // Injection: original/duplicate pair as the monitor would compare them.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            step(1, 0, 1, 16'h1234, 0, 0);
            step(1, 0, 1, 16'h1234, 0, 0);
            step(1, 0, 0, 16'h0, 1, 0);
            orig = data_out;
            step(1, 0, 0, 16'h0, 1, (pass == 0));
            dup = data_out;
            check($sformatf("inj%0d orig", pass), orig, 16'h1234);
            check($sformatf("inj%0d dup", pass), dup, (pass == 0) ? 16'h1235 : 16'h1234);
            check($sformatf("inj%0d qed_check", pass), (orig == dup), (pass == 0) ? 0 : 1);
            step(1, 0, 0, 16'h0, 0, 0);
            check($sformatf("inj%0d data held", pass), data_out,
                  (pass == 0) ? 16'h1235 : 16'h1234);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_aqed_fifo_responder
